fp_result_pack: RTL and testbench

FP_RESULT_PACK -- requirements
Module: fp_result_pack

---
 rtl/cva5_types.sv | 25 ++
 rtl/fp_result_pack_if.sv | 28 ++
 rtl/fp_flopoco_to_ieee.sv | 30 +++
 rtl/fp_result_pack.sv | 70 +++++++
 tb/tb_fp_result_pack.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/cva5_types.sv
// Shared FP result types: flopoco encodings, IEEE flag struct and instruction ids.
package cva5_types;

  localparam int ID_W = 4;
  typedef logic [ID_W-1:0] id_t;

  // [33:32] exception class, [31] sign, [30:23] exponent, [22:0] fraction
  typedef logic [33:0] flopoco_t;

  localparam logic [1:0] FP_ZERO   = 2'b00;
  localparam logic [1:0] FP_NORMAL = 2'b01;
  localparam logic [1:0] FP_INF    = 2'b10;
  localparam logic [1:0] FP_NAN    = 2'b11;

  localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_fflags_t;

endpackage

// File: rtl/fp_result_pack_if.sv
// Result-in / writeback-out bundle for fp_result_pack.
// Handshakes: a transfer happens on a clk edge where the valid (in_done / wb_done)
// and its ready (in_ack / wb_ack) are both 1; in_ack depends only on FIFO occupancy.
interface fp_result_pack_if;
  import cva5_types::*;

  logic       in_done;
  id_t        in_id;
  flopoco_t   in_rd;
  logic       in_ack;

  logic       wb_done;
  id_t        wb_id;
  logic [31:0] wb_rd;
  fp_fflags_t wb_fflags;
  logic       wb_ack;

  modport slave (
    input  in_done, in_id, in_rd, wb_ack,
    output in_ack, wb_done, wb_id, wb_rd, wb_fflags
  );

  modport master (
    output in_done, in_id, in_rd, wb_ack,
    input  in_ack, wb_done, wb_id, wb_rd, wb_fflags
  );

endinterface

// File: rtl/fp_flopoco_to_ieee.sv
// Combinational flopoco -> IEEE-754 single conversion; shared with divide/sqrt.
module fp_flopoco_to_ieee
  import cva5_types::*;
(
  input  flopoco_t    rd,
  output logic [31:0] result,
  output fp_fflags_t  fflags
);

  always_comb begin
    result = '0;
    fflags = '0;
    case (rd[33:32])
      FP_ZERO:   result = {rd[31], 31'b0};
      FP_NORMAL: begin
        if (rd[30:23] != 8'd0) begin
          result = rd[31:0];
        end else begin
          // no subnormal support: flush to signed zero and flag it
          result    = {rd[31], 31'b0};
          fflags.uf = 1'b1;
          fflags.nx = 1'b1;
        end
      end
      FP_INF:    result = {rd[31], 8'hFF, 23'b0};
      default:   result = CANONICAL_NAN;
    endcase
  end

endmodule

// File: rtl/fp_result_pack.sv
// Converts FP MAC results to IEEE form and buffers them in a small in-order
// FIFO ahead of writeback.
module fp_result_pack
  import cva5_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  fp_result_pack_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef struct packed {
    id_t         id;
    logic [31:0] rd;
    fp_fflags_t  fflags;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic [31:0]   conv_rd;
  fp_fflags_t    conv_fflags;
  logic          push;
  logic          pop;

  fp_flopoco_to_ieee u_conv (
    .rd     (bus.in_rd),
    .result (conv_rd),
    .fflags (conv_fflags)
  );

  assign bus.in_ack  = (count < DEPTH_C);
  assign bus.wb_done = (count != '0);
  assign push        = bus.in_done && bus.in_ack;
  assign pop         = bus.wb_done && bus.wb_ack;

  // Storage is deliberately not reset; the pointers and count gate its use.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{id: bus.in_id, rd: conv_rd, fflags: conv_fflags};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.wb_id     = mem[head].id;
  assign bus.wb_rd     = mem[head].rd;
  assign bus.wb_fflags = mem[head].fflags;

endmodule

// File: tb/tb_fp_result_pack.sv
// Directed bench for fp_result_pack: conversion classes, full/empty flow, wrap and reset.
module tb_fp_result_pack;
  import cva5_types::*;

  localparam int W = ID_W + 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [W-1:0] exp_q[$];

  fp_result_pack_if bus ();

  fp_result_pack #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input id_t id, input flopoco_t rd);
    bus.in_done = 1'b1;
    bus.in_id   = id;
    bus.in_rd   = rd;
    tick();
    bus.in_done = 1'b0;
  endtask

  task automatic pop_one();
    bus.wb_ack = 1'b1;
    tick();
    bus.wb_ack = 1'b0;
  endtask

  task automatic check_head(input string tag, input id_t id, input logic [31:0] rd, input logic [4:0] ff);
    check({tag, "_done"},   64'(bus.wb_done),   64'(1'b1));
    check({tag, "_id"},     64'(bus.wb_id),     64'(id));
    check({tag, "_rd"},     64'(bus.wb_rd),     64'(rd));
    check({tag, "_fflags"}, 64'(bus.wb_fflags), 64'(ff));
  endtask

  initial begin
    logic [W-1:0] e;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.in_done = 1'b0;
    bus.in_id   = '0;
    bus.in_rd   = '0;
    bus.wb_ack  = 1'b0;

    repeat (2) tick();
    check("rst_wb_done", 64'(bus.wb_done), 64'(1'b0));
    check("rst_in_ack",  64'(bus.in_ack),  64'(1'b1));
    rst = 1'b1;
    tick();

    // 1.0 with wb_ack held high: visible one cycle after push, gone the next
    bus.wb_ack = 1'b1;
    push_one(4'd3, {2'b01, 1'b0, 8'h7F, 23'd0});
    check_head("one", 4'd3, 32'h3F80_0000, 5'b00000);
    tick();
    check("one_empty", 64'(bus.wb_done), 64'(1'b0));
    bus.wb_ack = 1'b0;

    // NaN (sign ignored), then -inf
    push_one(4'd4, {2'b11, 1'b1, 8'h12, 23'h1234});
    push_one(4'd5, {2'b10, 1'b1, 8'h00, 23'h55});
    check_head("nan", 4'd4, 32'h7FC0_0000, 5'b00000);
    pop_one();
    check_head("ninf", 4'd5, 32'hFF80_0000, 5'b00000);
    pop_one();

    // normal with exp 0 flushes to -0 with UF|NX
    push_one(4'd6, {2'b01, 1'b1, 8'h00, 23'h40_0001});
    check_head("flush", 4'd6, 32'h8000_0000, 5'b00011);
    pop_one();

    // signed zero and a plain normal (3.0)
    push_one(4'd7, {2'b00, 1'b1, 8'h44, 23'h7});
    check_head("zero", 4'd7, 32'h8000_0000, 5'b00000);
    pop_one();
    push_one(4'd8, {2'b01, 1'b0, 8'h80, 23'h40_0000});
    check_head("norm", 4'd8, 32'h4040_0000, 5'b00000);
    pop_one();
    check("drained", 64'(bus.wb_done), 64'(1'b0));

    // fill with wb_ack=0: third push is refused until a pop frees a slot
    bus.in_done = 1'b1;
    bus.in_rd   = {2'b01, 1'b0, 8'h81, 23'd0};
    bus.in_id   = 4'd1;
    check("full_ack1", 64'(bus.in_ack), 64'(1'b1));
    tick();
    bus.in_id = 4'd2;
    check("full_ack2", 64'(bus.in_ack), 64'(1'b1));
    tick();
    bus.in_id = 4'd3;
    check("full_ack3", 64'(bus.in_ack), 64'(1'b0));
    tick();
    check("full_hold_ack", 64'(bus.in_ack), 64'(1'b0));
    check("full_hold_id",  64'(bus.wb_id),  64'(4'd1));
    bus.wb_ack = 1'b1;
    tick();
    check("full_pop1_id",  64'(bus.wb_id),  64'(4'd2));
    check("full_pop1_ack", 64'(bus.in_ack), 64'(1'b1));
    tick();
    bus.in_done = 1'b0;
    check_head("full_id3", 4'd3, 32'h4080_0000, 5'b00000);
    tick();
    check("full_empty", 64'(bus.wb_done), 64'(1'b0));
    bus.wb_ack = 1'b0;

    // steady state at count=1 across pointer wrap
    push_one(4'd0, {2'b01, 1'b0, 8'h81, 23'd0});
    exp_q.push_back({4'd0, 32'h4080_0000});
    bus.in_done = 1'b1;
    bus.wb_ack  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      bus.in_id = id_t'(k);
      bus.in_rd = {2'b01, 1'b0, 8'h81, 23'(k)};
      e = exp_q[0];
      check("wrap_id",  64'(bus.wb_id), 64'(e[W-1:32]));
      check("wrap_rd",  64'(bus.wb_rd), 64'(e[31:0]));
      check("wrap_cnt", 64'({bus.wb_done, bus.in_ack}), 64'(2'b11));
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back({id_t'(k), 1'b0, 8'h81, 23'(k)});
    end
    bus.in_done = 1'b0;
    e = exp_q.pop_front();
    check_head("wrap_last", e[W-1:32], e[31:0], 5'b00000);
    tick();
    check("wrap_empty", 64'(bus.wb_done), 64'(1'b0));
    bus.wb_ack = 1'b0;

    // asynchronous reset with two entries buffered
    push_one(4'd10, {2'b01, 1'b0, 8'h90, 23'd1});
    push_one(4'd11, {2'b01, 1'b0, 8'h91, 23'd2});
    check("pre_rst_ack", 64'(bus.in_ack), 64'(1'b0));
    #2;
    rst = 1'b0;
    #1;
    check("async_wb_done", 64'(bus.wb_done), 64'(1'b0));
    check("async_in_ack",  64'(bus.in_ack),  64'(1'b1));
    tick();
    rst = 1'b1;
    check("post_rst_empty", 64'(bus.wb_done), 64'(1'b0));
    push_one(4'd9, {2'b10, 1'b0, 8'h00, 23'd0});
    check_head("post_rst", 4'd9, 32'h7F80_0000, 5'b00000);
    pop_one();
    check("post_rst_drain", 64'(bus.wb_done), 64'(1'b0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
